// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C overwrite command decoder.
//   state_e      : framing FSM states
//   CMD_*        : bit positions inside an acknowledged command byte
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        DATA      = 3'd3,
        DATA_ACK  = 3'd4,
        WAIT_STOP = 3'd5
    } state_e;

    // byte[7]: 1 = timed override, 0 = persistent override
    localparam int CMD_HOLD_BIT = 7;
    // byte[1:0]: override enables for out_1/out_0
    localparam int CMD_OVR_LSB  = 0;
    localparam int CMD_OVR_MSB  = 1;

endpackage

// File: rtl/i2c_cond_detect.sv
// I2C bus condition detector for passive bus monitors.
// Registers SDA/SCL once and compares the live inputs against the
// registered copies.
//   clk, nrst : clock, synchronous active-low reset
//   sda_i     : debounced SDA
//   scl_i     : debounced SCL
//   rise_o    : SCL rising edge (data sample point)
//   start_o   : SDA falling while SCL stays high
//   stop_o    : SDA rising while SCL stays high
module i2c_cond_detect (
    input  logic clk,
    input  logic nrst,
    input  logic sda_i,
    input  logic scl_i,
    output logic rise_o,
    output logic start_o,
    output logic stop_o
);

    logic sda_q;
    logic scl_q;

    // Idle bus level is high on both lines.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            sda_q <= 1'b1;
            scl_q <= 1'b1;
        end else begin
            sda_q <= sda_i;
            scl_q <= scl_i;
        end
    end

    assign rise_o  = scl_i & ~scl_q;
    assign start_o = scl_i & scl_q & ~sda_i & sda_q;
    assign stop_o  = scl_i & scl_q & sda_i & ~sda_q;

endmodule

// File: rtl/i2c_overwrite_ctrl.sv
// Passive I2C slave-side command decoder driving the output override
// enables. Frames START/address/data/ACK/STOP and applies every ACK'd
// write byte addressed to TARGET_ADDR. Never drives the bus.
//   clk, nrst  : clock, synchronous active-low reset
//   sda, scl   : debounced bus lines
//   ovr_en     : bit0 overrides out_0, bit1 overrides out_1
//   last_cmd   : last acknowledged data byte
//   frame_done : 1-cycle pulse on STOP after a matched, ACK'd write
//   err        : 1-cycle pulse on START/STOP inside a truncated byte
module i2c_overwrite_ctrl
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int          HOLD_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       sda,
    input  logic       scl,
    output logic [1:0] ovr_en,
    output logic [7:0] last_cmd,
    output logic       frame_done,
    output logic       err
);

    localparam int            HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

    logic          rise, start, stop;
    state_e        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          wr_seen_q, wr_seen_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [1:0]    ovr_q, ovr_d;
    logic [7:0]    last_q, last_d;
    logic          fd_q, fd_d;
    logic          err_q, err_d;
    logic          cmd_ack;

    i2c_cond_detect u_cond (
        .clk     (clk),
        .nrst    (nrst),
        .sda_i   (sda),
        .scl_i   (scl),
        .rise_o  (rise),
        .start_o (start),
        .stop_o  (stop)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!nrst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ADDR;
        end else if (stop) begin
            state_d = IDLE;
        end else if (rise) begin
            case (state_q)
                ADDR:     if (bit_cnt_q == 4'd7) state_d = ADDR_ACK;
                ADDR_ACK: state_d = (!sda && shift_q[7:1] == TARGET_ADDR && !shift_q[0])
                                    ? DATA : WAIT_STOP;
                DATA:     if (bit_cnt_q == 4'd7) state_d = DATA_ACK;
                DATA_ACK: state_d = sda ? WAIT_STOP : DATA;
                default:  state_d = state_q;
            endcase
        end
    end

    // ---------------- FSM: outputs / datapath control ----------------
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        wr_seen_d = wr_seen_q;
        cmd_ack   = 1'b0;
        err_d     = (start | stop) & (state_q == ADDR || state_q == DATA) &
                    (bit_cnt_q != 4'd0);
        fd_d      = stop & wr_seen_q;
        if (start || stop) begin
            bit_cnt_d = 4'd0;
            if (stop) wr_seen_d = 1'b0;
        end else if (rise) begin
            case (state_q)
                ADDR, DATA: begin
                    shift_d   = {shift_q[6:0], sda};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                DATA_ACK: begin
                    bit_cnt_d = 4'd0;
                    // A data byte is only reachable after a matched write address.
                    if (!sda) begin
                        cmd_ack   = 1'b1;
                        wr_seen_d = 1'b1;
                    end
                end
                default: bit_cnt_d = 4'd0;
            endcase
        end
    end

    // Command application and hold timer; a new command wins over expiry.
    always_comb begin
        hold_d = hold_q;
        ovr_d  = ovr_q;
        last_d = last_q;
        if (cmd_ack) begin
            last_d = shift_q;
            ovr_d  = shift_q[CMD_OVR_MSB:CMD_OVR_LSB];
            hold_d = shift_q[CMD_HOLD_BIT] ? HOLD_LOAD : '0;
        end else if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
            if (hold_q == HW'(1)) ovr_d = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'd0;
            wr_seen_q <= 1'b0;
            hold_q    <= '0;
            ovr_q     <= 2'b00;
            last_q    <= 8'd0;
            fd_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            wr_seen_q <= wr_seen_d;
            hold_q    <= hold_d;
            ovr_q     <= ovr_d;
            last_q    <= last_d;
            fd_q      <= fd_d;
            err_q     <= err_d;
        end
    end

    assign ovr_en     = ovr_q;
    assign last_cmd   = last_q;
    assign frame_done = fd_q;
    assign err        = err_q;

endmodule

// File: tb/tb_i2c_overwrite_ctrl.sv
// Directed bench for i2c_overwrite_ctrl (HOLD_CYCLES = 20).
module tb_i2c_overwrite_ctrl;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       sda = 1'b1;
    logic       scl = 1'b1;
    logic [1:0] ovr_en;
    logic [7:0] last_cmd;
    logic       frame_done;
    logic       err;

    int ncmp = 0;
    int nfail = 0;
    int fd_cnt = 0;
    int err_cnt = 0;
    int ov1_cnt = 0;
    int base;

    always #5 clk = ~clk;

    i2c_overwrite_ctrl #(.TARGET_ADDR(7'h50), .HOLD_CYCLES(20)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .sda        (sda),
        .scl        (scl),
        .ovr_en     (ovr_en),
        .last_cmd   (last_cmd),
        .frame_done (frame_done),
        .err        (err)
    );

    // Pulse / level counters sampled on the falling edge.
    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
        if (err === 1'b1)        err_cnt <= err_cnt + 1;
        if (ovr_en === 2'b01)    ov1_cnt <= ov1_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        sda = b;  tick(2);
        scl = 1'b1; tick(2);
        scl = 1'b0; tick(1);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack);
        send_bits(b, 8);
        send_bit(~ack);
    endtask

    // Works from idle (SCL high) and as a repeated START (SCL low).
    task automatic i2c_start();
        sda = 1'b1; tick(2);
        scl = 1'b1; tick(2);
        sda = 1'b0; tick(2);
        scl = 1'b0; tick(2);
    endtask

    task automatic i2c_stop();
        sda = 1'b0; tick(2);
        scl = 1'b1; tick(2);
        sda = 1'b1; tick(3);
    endtask

    initial begin
        // Reset
        nrst = 1'b0; tick(3);
        check("rst_ovr", 16'(ovr_en), 16'h0);
        check("rst_last", 16'(last_cmd), 16'h0);
        check("rst_fd", 16'(frame_done), 16'h0);
        check("rst_err", 16'(err), 16'h0);
        nrst = 1'b1; tick(3);

        // T1: persistent 0x03, with ACK-slot timing
        base = fd_cnt;
        i2c_start();
        send_byte(8'hA0, 1'b1);
        send_bits(8'h03, 8);
        sda = 1'b0; tick(2);
        scl = 1'b1;
        check("t1_ovr_before_edge", 16'(ovr_en), 16'h0);
        tick(1);
        check("t1_ovr_at_edge", 16'(ovr_en), 16'h3);
        check("t1_last", 16'(last_cmd), 16'h03);
        tick(1);
        scl = 1'b0; tick(1);
        i2c_stop();
        check("t1_fd_pulses", 16'(fd_cnt - base), 16'd1);
        tick(1000);
        check("t1_ovr_persist", 16'(ovr_en), 16'h3);

        // T2: timed 0x81 -> 2'b01 for exactly 20 cycles
        base = ov1_cnt;
        i2c_start();
        send_byte(8'hA0, 1'b1);
        send_byte(8'h81, 1'b1);
        i2c_stop();
        tick(40);
        check("t2_ovr_cycles", 16'(ov1_cnt - base), 16'd20);
        check("t2_ovr_expired", 16'(ovr_en), 16'h0);
        check("t2_last", 16'(last_cmd), 16'h81);

        // T3: wrong address
        base = fd_cnt;
        i2c_start();
        send_byte(8'hA2, 1'b1);
        send_byte(8'h03, 1'b1);
        i2c_stop();
        check("t3_ovr", 16'(ovr_en), 16'h0);
        check("t3_last", 16'(last_cmd), 16'h81);
        check("t3_no_fd", 16'(fd_cnt - base), 16'd0);

        // T4: repeated START, second data byte NACKed
        i2c_start();
        send_byte(8'hA0, 1'b1);
        send_byte(8'h01, 1'b1);
        i2c_start();
        send_byte(8'hA0, 1'b1);
        send_byte(8'h02, 1'b0);
        i2c_stop();
        check("t4_ovr", 16'(ovr_en), 16'h1);
        check("t4_last", 16'(last_cmd), 16'h01);

        // T5: truncated address byte -> err, then valid frame
        i2c_start();
        send_bits(8'hA0, 4);
        base = err_cnt;
        i2c_stop();
        check("t5_err_pulse", 16'(err_cnt - base), 16'd1);
        check("t5_ovr_kept", 16'(ovr_en), 16'h1);
        base = fd_cnt;
        i2c_start();
        send_byte(8'hA0, 1'b1);
        send_byte(8'h02, 1'b1);
        i2c_stop();
        check("t5_ovr", 16'(ovr_en), 16'h2);
        check("t5_fd", 16'(fd_cnt - base), 16'd1);

        // T6: reset in the middle of a data byte
        i2c_start();
        send_byte(8'hA0, 1'b1);
        send_byte(8'h03, 1'b1);
        check("t6_ovr_pre", 16'(ovr_en), 16'h3);
        send_bits(8'h81, 3);
        nrst = 1'b0; tick(1);
        check("t6_rst_ovr", 16'(ovr_en), 16'h0);
        check("t6_rst_last", 16'(last_cmd), 16'h0);
        check("t6_rst_fd", 16'(frame_done), 16'h0);
        check("t6_rst_err", 16'(err), 16'h0);
        nrst = 1'b1;
        send_bits(8'h08, 5);
        send_bit(1'b0);
        check("t6_ignored_ovr", 16'(ovr_en), 16'h0);
        check("t6_ignored_last", 16'(last_cmd), 16'h0);
        base = fd_cnt;
        i2c_stop();
        check("t6_no_fd", 16'(fd_cnt - base), 16'd0);
        i2c_start();
        send_byte(8'hA0, 1'b1);
        send_byte(8'h02, 1'b1);
        i2c_stop();
        check("t6_fresh_ovr", 16'(ovr_en), 16'h2);
        check("t6_fresh_last", 16'(last_cmd), 16'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
